// File: rtl/p405s_srm_blr_pipe.sv
// rtl/p405s_srm_blr_pipe.sv - pipelined SRM barrel rotator/shifter with valid/ready on both sides
// Optional SRA carry output enabled by defining SRMBLR_CARRY_EN.
module p405s_srm_blr_pipe #(
   parameter int DATA_W      = 32,
   parameter int PIPE_STAGES = 2,
   parameter int IN_INV      = 1
) (
   input  logic                    CB,
   input  logic                    resetCore,
   input  logic                    inValid,
   output logic                    inReady,
   input  logic [DATA_W-1:0]       aBus,
   input  logic [$clog2(DATA_W):0] shAmt,
   input  logic [2:0]              op,
   output logic                    outValid,
   input  logic                    outReady,
`ifdef SRMBLR_CARRY_EN
   output logic                    outCarry,
`endif
   output logic [DATA_W-1:0]       outData
);

   localparam int SHAMT_W = $clog2(DATA_W);

   localparam logic [2:0] OP_ROTL = 3'b000;
   localparam logic [2:0] OP_ROTR = 3'b001;
   localparam logic [2:0] OP_SLL  = 3'b010;
   localparam logic [2:0] OP_SRL  = 3'b011;
   localparam logic [2:0] OP_SRA  = 3'b100;

   function automatic logic [DATA_W-1:0] low_mask(input logic [SHAMT_W-1:0] n);
      return ~({DATA_W{1'b1}} << n);
   endfunction

   // Applies only the rotate levels [lo, hi) owned by one pipeline stage.
   function automatic logic [DATA_W-1:0] rotl_levels(input logic [DATA_W-1:0] x,
                                                     input logic [SHAMT_W-1:0] amt,
                                                     input int lo,
                                                     input int hi);
      logic [DATA_W-1:0] r;
      r = x;
      for (int i = 0; i < SHAMT_W; i++) begin
         if (i >= lo && i < hi && amt[i]) begin
            r = (r << (1 << i)) | (r >> (DATA_W - (1 << i)));
         end
      end
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] finish_result(input logic [DATA_W-1:0] r,
                                                       input logic [SHAMT_W:0]   sh,
                                                       input logic [2:0]         f_op,
                                                       input logic               sign);
      logic [DATA_W-1:0] keep;
      logic              fill;
      keep = '0;
      fill = 1'b0;
      case (f_op)
         OP_ROTL, OP_ROTR: keep = '1;
         OP_SLL:           keep = sh[SHAMT_W] ? '0 : ~low_mask(sh[SHAMT_W-1:0]);
         OP_SRL:           keep = sh[SHAMT_W] ? '0 : ({DATA_W{1'b1}} >> sh[SHAMT_W-1:0]);
         OP_SRA: begin
            keep = sh[SHAMT_W] ? '0 : ({DATA_W{1'b1}} >> sh[SHAMT_W-1:0]);
            fill = sign;
         end
         default:          return '0;
      endcase
      return (r & keep) | (~keep & {DATA_W{fill}});
   endfunction

   logic              v_q     [PIPE_STAGES];
   logic              v_d     [PIPE_STAGES];
   logic [DATA_W-1:0] data_q  [PIPE_STAGES];
   logic [DATA_W-1:0] data_d  [PIPE_STAGES];
   logic [SHAMT_W-1:0] rot_q  [PIPE_STAGES];
   logic [SHAMT_W-1:0] rot_d  [PIPE_STAGES];
   logic [SHAMT_W:0]  sh_q    [PIPE_STAGES];
   logic [SHAMT_W:0]  sh_d    [PIPE_STAGES];
   logic [2:0]        op_q    [PIPE_STAGES];
   logic [2:0]        op_d    [PIPE_STAGES];
   logic              sign_q  [PIPE_STAGES];
   logic              sign_d  [PIPE_STAGES];
`ifdef SRMBLR_CARRY_EN
   logic              carry_q [PIPE_STAGES];
   logic              carry_d [PIPE_STAGES];
   logic              in_carry;
`endif
   logic              adv     [PIPE_STAGES];

   logic [DATA_W-1:0]  in_x;
   logic [SHAMT_W-1:0] in_rot;
   logic               in_sign;

   // Right-going ops become a left rotate by the two's complement amount.
   always_comb begin
      in_x    = (IN_INV != 0) ? ~aBus : aBus;
      in_sign = in_x[DATA_W-1];
      if (op == OP_ROTR || op == OP_SRL || op == OP_SRA) begin
         in_rot = '0 - shAmt[SHAMT_W-1:0];
      end else begin
         in_rot = shAmt[SHAMT_W-1:0];
      end
`ifdef SRMBLR_CARRY_EN
      in_carry = (op == OP_SRA) && in_sign &&
                 (shAmt[SHAMT_W] ? (|in_x) : (|(in_x & low_mask(shAmt[SHAMT_W-1:0]))));
`endif
   end

   always_comb begin
      logic               s_v;
      logic [DATA_W-1:0]  s_data;
      logic [SHAMT_W-1:0] s_rot;
      logic [SHAMT_W:0]   s_sh;
      logic [2:0]         s_op;
      logic               s_sign;
      logic [DATA_W-1:0]  r;
      int                 prev;
      int                 lo;
      int                 hi;
`ifdef SRMBLR_CARRY_EN
      logic               s_carry;
`endif

      adv[PIPE_STAGES-1] = !v_q[PIPE_STAGES-1] || outReady;
      for (int k = PIPE_STAGES - 2; k >= 0; k--) begin
         adv[k] = !v_q[k] || adv[k+1];
      end

      for (int k = 0; k < PIPE_STAGES; k++) begin
         prev = (k > 0) ? k - 1 : 0;
         if (k == 0) begin
            s_v    = inValid;
            s_data = in_x;
            s_rot  = in_rot;
            s_sh   = shAmt;
            s_op   = op;
            s_sign = in_sign;
`ifdef SRMBLR_CARRY_EN
            s_carry = in_carry;
`endif
         end else begin
            s_v    = v_q[prev];
            s_data = data_q[prev];
            s_rot  = rot_q[prev];
            s_sh   = sh_q[prev];
            s_op   = op_q[prev];
            s_sign = sign_q[prev];
`ifdef SRMBLR_CARRY_EN
            s_carry = carry_q[prev];
`endif
         end

         lo = k * SHAMT_W / PIPE_STAGES;
         hi = (k + 1) * SHAMT_W / PIPE_STAGES;
         r  = rotl_levels(s_data, s_rot, lo, hi);

         v_d[k]    = v_q[k];
         data_d[k] = data_q[k];
         rot_d[k]  = rot_q[k];
         sh_d[k]   = sh_q[k];
         op_d[k]   = op_q[k];
         sign_d[k] = sign_q[k];
`ifdef SRMBLR_CARRY_EN
         carry_d[k] = carry_q[k];
`endif
         // Payload only moves with a valid token so the output holds through bubbles.
         if (adv[k]) begin
            v_d[k] = s_v;
            if (s_v) begin
               rot_d[k]  = s_rot;
               sh_d[k]   = s_sh;
               op_d[k]   = s_op;
               sign_d[k] = s_sign;
               data_d[k] = (k == PIPE_STAGES - 1) ? finish_result(r, s_sh, s_op, s_sign) : r;
`ifdef SRMBLR_CARRY_EN
               carry_d[k] = s_carry;
`endif
            end
         end
      end
   end

   always_ff @(posedge CB) begin
      if (resetCore) begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            v_q[k]    <= 1'b0;
            data_q[k] <= '0;
            rot_q[k]  <= '0;
            sh_q[k]   <= '0;
            op_q[k]   <= '0;
            sign_q[k] <= 1'b0;
`ifdef SRMBLR_CARRY_EN
            carry_q[k] <= 1'b0;
`endif
         end
      end else begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            v_q[k]    <= v_d[k];
            data_q[k] <= data_d[k];
            rot_q[k]  <= rot_d[k];
            sh_q[k]   <= sh_d[k];
            op_q[k]   <= op_d[k];
            sign_q[k] <= sign_d[k];
`ifdef SRMBLR_CARRY_EN
            carry_q[k] <= carry_d[k];
`endif
         end
      end
   end

   assign inReady  = adv[0];
   assign outValid = v_q[PIPE_STAGES-1];
   assign outData  = data_q[PIPE_STAGES-1];
`ifdef SRMBLR_CARRY_EN
   assign outCarry = carry_q[PIPE_STAGES-1];
`endif

endmodule
